// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus: req/gnt request channel, in-order rvalid/rdata responses.
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches, buffers responses, hands one instruction per cycle
// to decode. Optional misaligned-redirect fault via `define IF_MISALIGN_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  if_stage_if.master  imem,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus_4_o,
  output logic [31:0] instruction_o
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault_o
`endif
);

  localparam logic [31:0] Nop  = 32'h0000_0013;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [OutW-1:0] outstanding_q, outstanding_d;
  logic [OutW-1:0] discard_q, discard_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] sq_wr_q, sq_wr_d, sq_rd_q, sq_rd_d;
  logic            fault_q, fault_d;

  logic [31:0] fifo_pc    [FIFO_DEPTH];
  logic [31:0] fifo_instr [FIFO_DEPTH];
  // PC of every granted request, popped by every response (stale ones included).
  logic [31:0] sq_pc      [FIFO_DEPTH];

  logic        grant, resp, push, pop;
  logic [31:0] target;

  // Low two bits are always dropped from the fetch target; the fault path inspects them.
  assign target = redirect_pc_i & 32'hFFFF_FFFC;

`ifdef IF_MISALIGN_CHECK_EN
  assign fault_d       = redirect_i ? (redirect_pc_i[1:0] != 2'b00) : fault_q;
  assign fetch_fault_o = fault_q;
`else
  assign fault_d       = 1'b0;
`endif

  // Occupancy includes in-flight requests, so every response is guaranteed a slot.
  assign imem.req  = rst_n && !fault_q &&
                     ((32'(count_q) + 32'(outstanding_q)) < FIFO_DEPTH) &&
                     (32'(outstanding_q) < MAX_OUTSTANDING);
  assign imem.addr = fetch_pc_q;

  assign grant = imem.req & imem.gnt;
  assign resp  = imem.rvalid;
  assign push  = resp && (discard_q == '0) && !redirect_i;
  assign pop   = valid_o && id_ready_i && !redirect_i;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + OutW'(grant) - OutW'(resp);
    discard_d     = discard_q;
    count_d       = count_q + CntW'(push) - CntW'(pop);
    wr_ptr_d      = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    sq_wr_d       = grant ? sq_wr_q + PtrW'(1) : sq_wr_q;
    sq_rd_d       = resp ? sq_rd_q + PtrW'(1) : sq_rd_q;

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (resp && (discard_q != '0)) begin
      discard_d = discard_q - OutW'(1);
    end

    if (redirect_i) begin
      fetch_pc_d = target;
      // Everything still in flight after this cycle belongs to the old stream.
      discard_d  = outstanding_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sq_wr_q       <= '0;
      sq_rd_q       <= '0;
      fault_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      sq_wr_q       <= sq_wr_d;
      sq_rd_q       <= sq_rd_d;
      fault_q       <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q]    <= sq_pc[sq_rd_q];
      fifo_instr[wr_ptr_q] <= imem.rdata;
    end
    if (grant) begin
      sq_pc[sq_wr_q] <= fetch_pc_q;
    end
  end

  assign valid_o       = (count_q != '0);
  assign pc_o          = valid_o ? fifo_pc[rd_ptr_q] : fetch_pc_q;
  assign pc_plus_4_o   = pc_o + 32'd4;
  assign instruction_o = valid_o ? fifo_instr[rd_ptr_q] : Nop;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order memory model returning the fetch address as data.
module tb_if_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        valid;
  logic [31:0] pc, pc4, instr;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  if_stage_if imem_bus ();

  if_stage #(
    .RESET_PC       (32'h0000_0000),
    .FIFO_DEPTH     (4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem_bus.master),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .id_ready_i   (id_ready),
    .valid_o      (valid),
    .pc_o         (pc),
    .pc_plus_4_o  (pc4),
    .instruction_o(instr)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .fetch_fault_o(fault)
`endif
  );

`ifndef IF_MISALIGN_CHECK_EN
  assign fault = 1'b0;
`endif

  always #5 clk = ~clk;

  // Memory model: requests granted in cycle c answer in cycle c+lat, in order.
  int          lat = 1;
  int          cyc = 0;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  initial begin
    logic        fire, used;
    logic [31:0] fire_addr;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = 32'h0;
    forever begin
      @(negedge clk);
      fire      = imem_bus.req & imem_bus.gnt;
      fire_addr = imem_bus.addr;
      used      = imem_bus.rvalid;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        q_addr.delete();
        q_due.delete();
        imem_bus.rvalid = 1'b0;
      end else begin
        if (used && q_addr.size() > 0) begin
          void'(q_addr.pop_front());
          void'(q_due.pop_front());
        end
        if (fire) begin
          q_addr.push_back(fire_addr);
          q_due.push_back(cyc + lat);
        end
        cyc++;
        imem_bus.rvalid = (q_addr.size() > 0) && (q_due[0] <= cyc);
        imem_bus.rdata  = (q_addr.size() > 0) ? q_addr[0] : 32'h0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Leaves the bench in cycle 0 right after reset release.
  task automatic reset_dut(input int l, input logic ready);
    rst_n        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    id_ready     = ready;
    imem_bus.gnt = 1'b1;
    lat          = l;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step(1);
    redirect    = 1'b0;
  endtask

  initial begin
    int          pops;
    logic [31:0] exp_pc;
    bit          found;

    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    id_ready     = 1'b0;
    imem_bus.gnt = 1'b0;
    #1 rst_n = 1'b0;
    #4;
    check("rst_req", 32'(imem_bus.req), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_instr", instr, Nop);
    check("rst_pc", pc, 32'h0);
    check("rst_fault", 32'(fault), 32'd0);

    // Zero-wait memory: valid at cycle 2, one instruction per cycle.
    reset_dut(1, 1'b1);
    check("c0_req", 32'(imem_bus.req), 32'd1);
    check("c0_addr", imem_bus.addr, 32'h0);
    step(1);
    check("c1_valid", 32'(valid), 32'd0);
    step(1);
    check("c2_valid", 32'(valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("seq_pc", pc, 32'(4 * i));
      check("seq_pc4", pc4, 32'(4 * i + 4));
      check("seq_instr", instr, 32'(4 * i));
      step(1);
    end

    // Backpressure: FIFO fills, requests stop, head holds, then drains in order.
    reset_dut(1, 1'b0);
    step(10);
    check("bp_req", 32'(imem_bus.req), 32'd0);
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_pc", pc, 32'h0);
    id_ready = 1'b1;
    pops     = 0;
    exp_pc   = 32'h0;
    for (int i = 0; i < 12; i++) begin
      if (valid) begin
        check("drain_pc", pc, exp_pc);
        check("drain_instr", instr, exp_pc);
        exp_pc += 32'd4;
        pops++;
      end
      step(1);
    end
    check("drain_pops", 32'(pops), 32'd12);

    // Two stale requests in flight when redirecting.
    reset_dut(3, 1'b1);
    step(2);
    do_redirect(32'h100);
    check("rd_valid", 32'(valid), 32'd0);
    check("rd_addr", imem_bus.addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (valid) begin
        found = 1'b1;
        check("rd_pc", pc, 32'h100);
        check("rd_instr", instr, 32'h100);
      end else begin
        check("rd_nop", instr, Nop);
        step(1);
      end
    end
    check("rd_found", 32'(found), 32'd1);

    // Redirect coinciding with an rvalid and a grant.
    reset_dut(1, 1'b1);
    step(3);
    check("co_rvalid", 32'(imem_bus.rvalid), 32'd1);
    check("co_req", 32'(imem_bus.req), 32'd1);
    do_redirect(32'h300);
    check("co_valid4", 32'(valid), 32'd0);
    check("co_addr", imem_bus.addr, 32'h300);
    step(1);
    check("co_valid5", 32'(valid), 32'd0);
    step(1);
    check("co_valid6", 32'(valid), 32'd1);
    check("co_pc", pc, 32'h300);
    check("co_instr", instr, 32'h300);

    // Address wrap at 2^32.
    reset_dut(1, 1'b1);
    step(3);
    do_redirect(32'hFFFF_FFFC);
    check("wr_addr1", imem_bus.addr, 32'hFFFF_FFFC);
    step(1);
    check("wr_addr2", imem_bus.addr, 32'h0);
    step(1);
    check("wr_pc", pc, 32'hFFFF_FFFC);
    check("wr_pc4", pc4, 32'h0);
    step(1);
    check("wr_next", pc, 32'h0);

    // Misaligned redirect.
    reset_dut(1, 1'b1);
    step(3);
    do_redirect(32'h102);
`ifdef IF_MISALIGN_CHECK_EN
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("mis_noreq", 32'(imem_bus.req), 32'd0);
      step(1);
    end
    do_redirect(32'h200);
    check("mis_clear", 32'(fault), 32'd0);
    check("mis_addr", imem_bus.addr, 32'h200);
    step(2);
    check("mis_pc", pc, 32'h200);
`else
    check("al_addr", imem_bus.addr, 32'h100);
    step(2);
    check("al_valid", 32'(valid), 32'd1);
    check("al_pc", pc, 32'h100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage: the producer feeding the decode stage's pc/pc+4/instruction inputs.
- Issues word fetches to instruction memory over a req/gnt/rvalid interface and buffers responses in a small FIFO.
- Presents one instruction per cycle to decode under a valid/ready handshake.
- Handles redirects (branch/jump) by flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, >=2.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered memory requests; 1..FIFO_DEPTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, word aligned
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; responses return in order
- imem_rdata_i  in  32  response instruction word
- redirect_i  in  1  flush and restart at redirect_pc_i
- redirect_pc_i  in  32  new fetch target
- id_ready_i  in  1  decode accepts the head entry
- valid_o  out  1  head entry valid
- pc_o  out  32  PC of head instruction
- pc_plus_4_o  out  32  pc_o + 4, modulo 2^32
- instruction_o  out  32  head instruction; 32'h00000013 (NOP) when valid_o=0
- fetch_fault_o  out  1  misaligned redirect fault; exists only with IF_MISALIGN_CHECK_EN

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - imem_req_o=0, valid_o=0, instruction_o=NOP, pc_o=RESET_PC, fetch_fault_o=0.
- First cycle after rst_n rises: imem_req_o=1, imem_addr_o=RESET_PC.
- Request issue:
  - imem_req_o=1 iff (fifo_count + outstanding) < FIFO_DEPTH, outstanding < MAX_OUTSTANDING, and no fault is held.
  - The occupancy check guarantees every response has a FIFO slot; responses are never back-pressured.
  - req&gnt: outstanding+1 and fetch_pc+=4 (wraps at 2^32).
  - req without gnt: address holds until gnt, except that a redirect may withdraw it.
- Response handling (imem_rvalid_i=1, outstanding-1):
  - If discard>0: data dropped, discard-1.
  - Otherwise: write {pc, rdata} into the FIFO tail. The pc for each entry is tracked per granted request in a side queue.
- Output handshake:
  - valid_o = FIFO not empty; pc_o, instruction_o and pc_plus_4_o come from the head.
  - valid_o & id_ready_i pops the head. A pop and a push in the same cycle are both applied.
  - Outputs are held while valid_o & !id_ready_i.
- Latency: response at cycle T makes valid_o=1 at T+1 (registered FIFO). Zero-wait memory (gnt same cycle, rvalid next) gives 2 cycles from req to valid_o.
- Redirect (cycle N):
  - FIFO cleared; valid_o=0 at N+1.
  - fetch_pc = redirect_pc_i; imem_addr_o = target at N+1.
  - discard = outstanding after the cycle N updates. This includes a request granted in cycle N and excludes an rvalid consumed in cycle N, which is itself dropped.
  - A pop in cycle N is ignored. id_ready_i at N is don't-care.
  - Back-to-back redirects: the last one wins. discard accumulates correctly.
- Reset mid-operation: everything returns to reset state immediately. Any pending memory responses are the environment's responsibility; the bench resets memory too.

Optional Feature:
- IF_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc_i[1:0]!=0 sets fetch_fault_o=1 at N+1 and holds imem_req_o=0.
  - The FIFO is still flushed.
  - The fault clears on the next aligned redirect, which fetches normally.
- Undefined:
  - Port fetch_fault_o is absent.
  - redirect_pc_i[1:0] is forced to 2'b00 and fetching continues.

Test Plan:
- Reset release, zero-wait memory returning addr as data -> valid_o at cycle 2; pc_o 0x0,0x4,0x8,... with pc_plus_4_o=pc_o+4; one pop per cycle with id_ready_i=1.
- id_ready_i=0 for 10 cycles -> FIFO fills to 4; imem_req_o drops to 0; head stays pc_o=0x0. Release -> drains in order with no loss or duplication.
- 2 outstanding requests (rvalid delay 3), redirect_i to 0x100 -> both stale responses dropped; first valid_o shows pc_o=0x100; instruction_o=NOP while invalid.
- Redirect in the same cycle as an rvalid and a gnt -> both stale words discarded (discard=1 after cycle); next output pc_o=target.
- fetch_pc=0xFFFFFFFC -> next fetch address 0x00000000; pc_plus_4_o=0x00000000.
- IF_MISALIGN_CHECK_EN: redirect to 0x102 -> fetch_fault_o=1, no requests; redirect to 0x200 -> fault clears, pc_o=0x200. Without the macro: redirect to 0x102 -> fetch 0x100.
